// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3/size encodings and op legality check for the LSU
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  // Unused funct3 codes, and unsigned variants on stores, never reach memory
  function automatic logic op_illegal(input logic we, input logic [2:0] funct3);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
           (we && funct3[2]);
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// rtl/lsu_load_ext.sv - sign/zero extension of raw memory read data by funct3
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  // Select width and extension; unknown codes pass the word through untouched
  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{rdata[7]}}, rdata[7:0]};
      F3_BU:   result = {24'h0, rdata[7:0]};
      F3_H:    result = {{16{rdata[15]}}, rdata[15:0]};
      F3_HU:   result = {16'h0, rdata[15:0]};
      F3_W:    result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// rtl/lsu_master.sv - load/store unit memory initiator with ack timeout; option LSU_MISALIGN_TRAP_EN
module lsu_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e     state_q, state_d;
  logic           we_q;
  logic [2:0]     f3_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [CW-1:0]  cnt_q;
  logic           err_q;
  logic [31:0]    rdata_q;
  logic [31:0]    ext_data;
  logic           misalign;
  logic           in_access;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  lsu_load_ext u_ext (
    .funct3 (f3_q),
    .rdata  (mem_rdata),
    .result (ext_data)
  );

  // Next-state: rejected ops skip straight to RESP; ack beats terminal count
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (op_illegal(req_we, req_funct3) || misalign) state_d = RESP;
          else                                            state_d = ACCESS;
        end
      end
      ACCESS:  if (mem_ack || (cnt_q == TERM)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state so reset drops the strobes immediately
  always_comb begin
    in_access  = (state_q == ACCESS);
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = rdata_q;
    mem_rd_en  = in_access && !we_q;
    mem_wr_en  = in_access && we_q;
    mem_addr   = in_access ? addr_q : 32'h0;
    mem_wdata  = in_access ? wdata_q : 32'h0;
    mem_size   = in_access ? {1'b0, f3_q[1:0]} : SZ_BYTE;
  end

  // State, request capture, timeout counter and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (state_d == RESP) begin
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_ack) begin
            err_q   <= 1'b0;
            rdata_q <= we_q ? 32'h0 : ext_data;
          end else if (cnt_q == TERM) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end
        end
        RESP:    cnt_q <= '0;
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// tb/tb_lsu_master.sv - directed self-checking bench for lsu_master
module tb_lsu_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int tests  = 0;
  int failed = 0;
  int n;

  lsu_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_wr_en  (mem_wr_en),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_size   (mem_size),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one request across a single posedge
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  // Load against a memory that acks in its first strobe cycle
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] rd,
                          input logic [31:0] exp);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    issue(1'b0, f3, 32'h100, 32'h0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_err"}, {31'h0, resp_err}, 32'h0);
    chk({tag, "_rdata"}, resp_rdata, exp);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;

    // reset state
    #2;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_outs", {29'h0, resp_valid, resp_err, mem_rd_en | mem_wr_en}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: LW, ack tied high
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_rd_en", {30'h0, mem_rd_en, mem_wr_en}, 32'h2);
    chk("lw_addr", mem_addr, 32'h10);
    chk("lw_size", {29'h0, mem_size}, 32'h2);
    chk("lw_ready_busy", {30'h0, req_ready, resp_valid}, 32'h0);
    @(negedge clk);
    chk("lw_resp", {29'h0, resp_valid, resp_err, mem_rd_en}, 32'h4);
    chk("lw_rdata", resp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("lw_idle", {30'h0, req_ready, resp_valid}, 32'h2);
    chk("lw_hold", resp_rdata, 32'hDEADBEEF);

    // 2: extension
    run_load("lb", 3'b000, 32'h00000080, 32'hFFFFFF80);
    run_load("lbu", 3'b100, 32'h00000080, 32'h00000080);
    run_load("lh", 3'b001, 32'h00008001, 32'hFFFF8001);
    run_load("lhu", 3'b101, 32'hABCD8001, 32'h00008001);

    // 3: SH with ack in third strobe cycle
    mem_ack = 1'b0;
    issue(1'b1, 3'b001, 32'h22, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      chk("sh_wr_en", {30'h0, mem_wr_en, mem_rd_en}, 32'h2);
      chk("sh_size", {29'h0, mem_size}, 32'h1);
      chk("sh_addr", mem_addr, 32'h22);
      chk("sh_wdata", mem_wdata, 32'h12345678);
      chk("sh_noresp", {31'h0, resp_valid}, 32'h0);
      if (i == 2) mem_ack = 1'b1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk("sh_resp", {29'h0, resp_valid, resp_err, mem_wr_en}, 32'h4);
    chk("sh_rdata", resp_rdata, 32'h0);
    @(negedge clk);

    // 4a: timeout after exactly 16 strobe cycles (prior rdata nonzero)
    mem_rdata = 32'h11111111;
    run_load("pre_to", 3'b010, 32'h5A5A5A5A, 32'h5A5A5A5A);
    mem_ack = 1'b0;
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) break;
      if (mem_rd_en) n++;
      @(negedge clk);
    end
    chk("to_cycles", n, 32'd16);
    chk("to_resp", {30'h0, resp_valid, resp_err}, 32'h3);
    chk("to_rdata", resp_rdata, 32'h0);
    @(negedge clk);

    // 4b: ack on the terminal-count cycle wins
    issue(1'b0, 3'b000, 32'h44, 32'h0);
    for (int i = 0; i < 15; i++) @(negedge clk);
    chk("tc_still_rd", {31'h0, mem_rd_en}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h000000FE;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("tc_resp", {30'h0, resp_valid, resp_err}, 32'h2);
    chk("tc_rdata", resp_rdata, 32'hFFFFFFFE);
    @(negedge clk);

    // 5: illegal ops respond one cycle after accept with no strobes
    issue(1'b0, 3'b011, 32'h50, 32'h0);
    chk("ill_ld", {28'h0, resp_valid, resp_err, mem_rd_en, mem_wr_en}, 32'hC);
    chk("ill_ld_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    issue(1'b1, 3'b100, 32'h54, 32'hFFFF);
    chk("ill_st", {28'h0, resp_valid, resp_err, mem_rd_en, mem_wr_en}, 32'hC);
    @(negedge clk);
    chk("ill_idle", {31'h0, req_ready}, 32'h1);

    // 6: async reset mid-access drops strobes, no response
    mem_ack = 1'b0; mem_rdata = 32'h0;
    run_load("pre_rst", 3'b010, 32'h77, 32'h77);
    mem_ack = 1'b0;
    issue(1'b0, 3'b010, 32'h60, 32'h0);
    chk("mid_rd", {31'h0, mem_rd_en}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("rst_drop", {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
    chk("rst_noresp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_after", {30'h0, req_ready, resp_valid}, 32'h2);
    chk("rst_rdata_clr", resp_rdata, 32'h0);

    // 6b: misaligned LW
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    issue(1'b0, 3'b010, 32'h02, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_trap", {28'h0, resp_valid, resp_err, mem_rd_en, mem_wr_en}, 32'hC);
`else
    chk("mis_fwd_rd", {31'h0, mem_rd_en}, 32'h1);
    chk("mis_fwd_addr", mem_addr, 32'h02);
    @(negedge clk);
    chk("mis_fwd_resp", {30'h0, resp_valid, resp_err}, 32'h2);
    chk("mis_fwd_rdata", resp_rdata, 32'hCAFEF00D);
`endif
    @(negedge clk);
    mem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
